// File: rtl/chacha_xor_stream.sv
// ChaCha20 keystream XOR stage: one plaintext byte in, one ciphertext byte out per cycle.
// Fetches one 64-byte keystream block per 64 message bytes and drives the block counter.
module chacha_xor_stream #(
  parameter int DATA_SIZE   = 8,
  parameter int BLOCK_BYTES = 64,
  parameter int LEN_W       = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [LEN_W-1:0]                msg_len,
  input  logic [31:0]                     init_counter,
  output logic                            ks_req,
  output logic [31:0]                     ks_counter,
  input  logic                            ks_valid,
  input  logic [DATA_SIZE*BLOCK_BYTES-1:0] ks_block,
  input  logic                            pt_valid,
  input  logic [DATA_SIZE-1:0]            pt_data,
  output logic                            pt_ready,
  output logic                            ct_valid,
  output logic [DATA_SIZE-1:0]            ct_data,
  output logic                            ct_last,
  input  logic                            ct_ready,
  output logic                            busy,
  output logic                            done
);

  localparam int KS_W  = DATA_SIZE * BLOCK_BYTES;
  localparam int IDX_W = $clog2(BLOCK_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_KS, XOR, DRAIN, DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [LEN_W-1:0]       rem_q, rem_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [31:0]            ctr_q, ctr_d;
  logic [KS_W-1:0]        ks_buf_q, ks_buf_d;
  logic                   ct_valid_q, ct_valid_d;
  logic                   ct_last_q, ct_last_d;
  logic [DATA_SIZE-1:0]   ct_data_q, ct_data_d;
  logic [DATA_SIZE-1:0]   ks_byte;
  logic                   accept;

  assign ks_byte = ks_buf_q[DATA_SIZE*idx_q +: DATA_SIZE];

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    ctr_d      = ctr_q;
    ks_buf_d   = ks_buf_q;
    ct_valid_d = ct_valid_q;
    ct_last_d  = ct_last_q;
    ct_data_d  = ct_data_q;
    pt_ready   = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = msg_len;
          ctr_d   = init_counter;
          idx_d   = '0;
          state_d = (msg_len == '0) ? DONE : WAIT_KS;
        end
      end
      WAIT_KS: begin
        if (ks_valid) begin
          ks_buf_d = ks_block;
          state_d  = XOR;
        end
      end
      XOR: begin
        pt_ready = !ct_valid_q || ct_ready;
        if (pt_valid && pt_ready) begin
          accept = 1'b1;
          idx_d  = idx_q + IDX_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end else if (idx_q == LAST_IDX) begin
            // Block exhausted with bytes still to go: fetch the next one.
            ctr_d   = ctr_q + 32'd1;
            idx_d   = '0;
            state_d = WAIT_KS;
          end
        end
      end
      DRAIN: begin
        if (ct_valid_q && ct_ready) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      ct_valid_d = 1'b1;
      ct_data_d  = pt_data ^ ks_byte;
      ct_last_d  = (rem_q == LEN_W'(1));
    end else if (ct_ready) begin
      ct_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      idx_q      <= '0;
      ctr_q      <= '0;
      ks_buf_q   <= '0;
      ct_valid_q <= 1'b0;
      ct_last_q  <= 1'b0;
      ct_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      ctr_q      <= ctr_d;
      ks_buf_q   <= ks_buf_d;
      ct_valid_q <= ct_valid_d;
      ct_last_q  <= ct_last_d;
      ct_data_q  <= ct_data_d;
    end
  end

  assign ks_req     = (state_q == WAIT_KS);
  assign ks_counter = ctr_q;
  assign ct_valid   = ct_valid_q;
  assign ct_data    = ct_data_q;
  assign ct_last    = ct_last_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_chacha_xor_stream.sv
// Directed bench for chacha_xor_stream: RFC 8439 vector, full block,
// back-pressure, empty message, counter wrap and mid-message reset.
module tb_chacha_xor_stream;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  msg_len = '0;
  logic [31:0]  init_counter = '0;
  logic         ks_req;
  logic [31:0]  ks_counter;
  logic         ks_valid = 1'b0;
  logic [511:0] ks_block = '0;
  logic         pt_valid = 1'b0;
  logic [7:0]   pt_data = '0;
  logic         pt_ready;
  logic         ct_valid;
  logic [7:0]   ct_data;
  logic         ct_last;
  logic         ct_ready = 1'b1;
  logic         busy;
  logic         done;

  chacha_xor_stream dut (
    .clk(clk), .rst(rst), .start(start), .msg_len(msg_len),
    .init_counter(init_counter), .ks_req(ks_req), .ks_counter(ks_counter),
    .ks_valid(ks_valid), .ks_block(ks_block), .pt_valid(pt_valid),
    .pt_data(pt_data), .pt_ready(pt_ready), .ct_valid(ct_valid),
    .ct_data(ct_data), .ct_last(ct_last), .ct_ready(ct_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [511:0] ks_mem [3];
  logic [7:0]   pt_mem [128];
  logic [7:0]   ct_q [$];
  logic         last_q [$];
  logic [31:0]  cnt_log [$];
  int           req_idx = 0;
  int           ks_req_cnt = 0;
  int           done_cnt = 0;
  int           ctv_cnt = 0;
  int           stall_err = 0;
  int           mirror_err = 0;
  bit           bp_en = 1'b0;
  bit           prev_stall = 1'b0;
  logic [7:0]   prev_data;
  logic         prev_last;

  string rfc_pt = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";

  // Keystream source: answers each request in the cycle after ks_req rises.
  initial forever begin
    @(negedge clk);
    if (ks_valid) begin
      ks_valid = 1'b0;
    end else if (ks_req && !rst) begin
      ks_block = ks_mem[req_idx % 3];
      cnt_log.push_back(ks_counter);
      req_idx++;
      ks_valid = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    ct_ready = bp_en ? ~ct_ready : 1'b1;
  end

  // Output monitor, sampled mid-cycle after all inputs have settled.
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (ct_valid && ct_ready) begin
        ct_q.push_back(ct_data);
        last_q.push_back(ct_last);
      end
      if (ks_req) ks_req_cnt++;
      if (done) done_cnt++;
      if (ct_valid) ctv_cnt++;
      if (prev_stall && (!ct_valid || ct_data !== prev_data || ct_last !== prev_last))
        stall_err++;
      if (ct_valid && !ct_ready && pt_ready) mirror_err++;
      prev_stall = ct_valid && !ct_ready;
      prev_data  = ct_data;
      prev_last  = ct_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic [7:0] model_ct(input int i);
    logic [511:0] blk;
    blk = ks_mem[i / 64];
    return pt_mem[i] ^ blk[8*(i % 64) +: 8];
  endfunction

  task automatic clear_log();
    ct_q.delete();
    last_q.delete();
    cnt_log.delete();
    req_idx    = 0;
    ks_req_cnt = 0;
    done_cnt   = 0;
    ctv_cnt    = 0;
    stall_err  = 0;
    mirror_err = 0;
  endtask

  task automatic fill_ks();
    for (int b = 0; b < 3; b++)
      for (int j = 0; j < 64; j++)
        ks_mem[b][8*j +: 8] = 8'(j * 37 + b * 101 + 5);
  endtask

  task automatic do_start(input int len, input logic [31:0] ctr);
    @(negedge clk);
    start        = 1'b1;
    msg_len      = 16'(len);
    init_counter = ctr;
    @(negedge clk);
    start        = 1'b0;
    msg_len      = 16'hdead;
    init_counter = 32'h5a5a5a5a;
  endtask

  task automatic drive_pt(input int n, input int stop, output bit to);
    int i = 0;
    int cyc = 0;
    to = 1'b0;
    while (i < n && i != stop) begin
      @(negedge clk);
      pt_valid = 1'b1;
      pt_data  = pt_mem[i];
      #1;
      if (pt_ready) i++;
      cyc++;
      if (cyc > 2000) begin
        to = 1'b1;
        break;
      end
    end
    @(negedge clk);
    pt_valid = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit to);
    int c = 0;
    while (done_cnt == 0 && c < lim) begin
      @(negedge clk);
      #3;
      c++;
    end
    to = (done_cnt == 0);
    repeat (2) @(negedge clk);
    #3;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({ks_req, pt_ready, ct_valid, ct_last, busy, done} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 000000",
               {ks_req, pt_ready, ct_valid, ct_last, busy, done});
    end
    tests++;
    if (ks_counter !== 32'd0) begin
      fails++;
      $display("FAIL reset_ks_counter got %h want 0", ks_counter);
    end
    tests++;
    if (ct_data !== 8'd0) begin
      fails++;
      $display("FAIL reset_ct_data got %h want 0", ct_data);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rfc();
    bit to;
    bit dto;
    logic [511:0] blk;
    fill_ks();
    blk = ks_mem[0];
    blk[31:0] = 32'hf3514f22;
    ks_mem[0] = blk;
    blk = ks_mem[1];
    blk[8*49 +: 8] = 8'h63;
    ks_mem[1] = blk;
    for (int i = 0; i < 114; i++) pt_mem[i] = rfc_pt[i];
    clear_log();
    do_start(114, 32'd1);
    drive_pt(114, -1, to);
    wait_done(200, dto);
    tests++;
    if (to || dto) begin
      fails++;
      $display("FAIL rfc_timeout got %0d/%0d want 0/0", to, dto);
    end
    tests++;
    if (cnt_log.size() != 2 || cnt_log[0] !== 32'd1 || cnt_log[1] !== 32'd2) begin
      fails++;
      $display("FAIL rfc_counters got n=%0d want 1,2", cnt_log.size());
    end
    tests++;
    if (ks_req_cnt != 2) begin
      fails++;
      $display("FAIL rfc_req_cycles got %0d want 2", ks_req_cnt);
    end
    tests++;
    if (ct_q.size() != 114) begin
      fails++;
      $display("FAIL rfc_count got %0d want 114", ct_q.size());
    end else begin
      tests++;
      if ({ct_q[0], ct_q[1], ct_q[2], ct_q[3]} !== 32'h6e2e359a) begin
        fails++;
        $display("FAIL rfc_first4 got %h%h%h%h want 6e2e359a",
                 ct_q[0], ct_q[1], ct_q[2], ct_q[3]);
      end
      tests++;
      if (ct_q[113] !== 8'h4d || last_q[113] !== 1'b1) begin
        fails++;
        $display("FAIL rfc_last got %h/%b want 4d/1", ct_q[113], last_q[113]);
      end
      for (int i = 0; i < 114; i++) begin
        tests++;
        if (ct_q[i] !== model_ct(i) || (i < 113 && last_q[i] !== 1'b0)) begin
          fails++;
          $display("FAIL rfc_byte%0d got %h/%b want %h", i, ct_q[i], last_q[i], model_ct(i));
        end
      end
    end
    tests++;
    if (done_cnt != 1) begin
      fails++;
      $display("FAIL rfc_done got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_full_block();
    bit to;
    bit dto;
    ks_mem[0] = {512{1'b1}};
    for (int i = 0; i < 64; i++) pt_mem[i] = 8'(i);
    clear_log();
    do_start(64, 32'd7);
    drive_pt(64, -1, to);
    wait_done(200, dto);
    tests++;
    if (to || dto || ks_req_cnt != 1) begin
      fails++;
      $display("FAIL blk_reqs got to=%0d dto=%0d req=%0d want 0 0 1", to, dto, ks_req_cnt);
    end
    tests++;
    if (ks_counter !== 32'd7) begin
      fails++;
      $display("FAIL blk_counter got %h want 7", ks_counter);
    end
    tests++;
    if (ct_q.size() != 64) begin
      fails++;
      $display("FAIL blk_count got %0d want 64", ct_q.size());
    end else begin
      for (int i = 0; i < 64; i++) begin
        tests++;
        if (ct_q[i] !== 8'(8'hff - i) || last_q[i] !== (i == 63)) begin
          fails++;
          $display("FAIL blk_byte%0d got %h/%b want %h/%b",
                   i, ct_q[i], last_q[i], 8'(8'hff - i), (i == 63));
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    bit to;
    bit dto;
    fill_ks();
    for (int i = 0; i < 10; i++) pt_mem[i] = 8'(i * 7 + 3);
    clear_log();
    bp_en = 1'b1;
    do_start(10, 32'd3);
    drive_pt(10, -1, to);
    wait_done(200, dto);
    bp_en = 1'b0;
    tests++;
    if (to || dto) begin
      fails++;
      $display("FAIL bp_timeout got %0d/%0d want 0/0", to, dto);
    end
    tests++;
    if (stall_err != 0 || mirror_err != 0) begin
      fails++;
      $display("FAIL bp_stall got stall=%0d mirror=%0d want 0 0", stall_err, mirror_err);
    end
    tests++;
    if (ct_q.size() != 10) begin
      fails++;
      $display("FAIL bp_count got %0d want 10", ct_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        tests++;
        if (ct_q[i] !== model_ct(i) || last_q[i] !== (i == 9)) begin
          fails++;
          $display("FAIL bp_byte%0d got %h want %h", i, ct_q[i], model_ct(i));
        end
      end
    end
  endtask

  task automatic test_zero_len();
    clear_log();
    do_start(0, 32'd11);
    repeat (4) @(negedge clk);
    #3;
    tests++;
    if (done_cnt != 1 || ks_req_cnt != 0 || ctv_cnt != 0) begin
      fails++;
      $display("FAIL zero_len got done=%0d req=%0d ctv=%0d want 1 0 0",
               done_cnt, ks_req_cnt, ctv_cnt);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_wrap();
    bit to;
    bit dto;
    fill_ks();
    for (int i = 0; i < 65; i++) pt_mem[i] = 8'(i ^ 8'h5c);
    clear_log();
    do_start(65, 32'hffffffff);
    drive_pt(65, -1, to);
    wait_done(300, dto);
    tests++;
    if (to || dto || cnt_log.size() != 2) begin
      fails++;
      $display("FAIL wrap_reqs got n=%0d want 2", cnt_log.size());
    end else begin
      tests++;
      if (cnt_log[0] !== 32'hffffffff || cnt_log[1] !== 32'h0) begin
        fails++;
        $display("FAIL wrap_counter got %h,%h want ffffffff,00000000",
                 cnt_log[0], cnt_log[1]);
      end
    end
    tests++;
    if (ct_q.size() != 65 || ct_q[64] !== model_ct(64) || last_q[64] !== 1'b1) begin
      fails++;
      $display("FAIL wrap_last got n=%0d want 65 ending %h", ct_q.size(), model_ct(64));
    end
  endtask

  task automatic test_mid_reset();
    bit to;
    bit dto;
    fill_ks();
    for (int i = 0; i < 100; i++) pt_mem[i] = 8'(i * 3 + 1);
    clear_log();
    do_start(100, 32'd20);
    drive_pt(100, 30, to);
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if ({ks_req, pt_ready, ct_valid, ct_last, busy, done} !== 6'b0 ||
        ks_counter !== 32'd0 || ct_data !== 8'd0) begin
      fails++;
      $display("FAIL midrst_outputs got %b ctr=%h ct=%h want zeros",
               {ks_req, pt_ready, ct_valid, ct_last, busy, done}, ks_counter, ct_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_log();
    do_start(5, 32'd9);
    drive_pt(5, -1, to);
    wait_done(100, dto);
    tests++;
    if (to || dto || cnt_log.size() != 1 || cnt_log[0] !== 32'd9) begin
      fails++;
      $display("FAIL midrst_restart got to=%0d dto=%0d n=%0d want 0 0 1", to, dto, cnt_log.size());
    end
    tests++;
    if (ct_q.size() != 5) begin
      fails++;
      $display("FAIL midrst_count got %0d want 5", ct_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (ct_q[i] !== model_ct(i) || last_q[i] !== (i == 4)) begin
          fails++;
          $display("FAIL midrst_byte%0d got %h want %h", i, ct_q[i], model_ct(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rfc();
    test_full_block();
    test_back_pressure();
    test_zero_len();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
